bus_transfer_controller: RTL and testbench
==========================================

BUS_TRANSFER_CONTROLLER -- requirements
Module: bus_transfer_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bus and register data width.
REQ-002 SHALL have parameter ADDR_W, default 6: width of the register address.
REQ-003 SHALL have parameter NUM_REGS, default 4: number of implemented registers in the downstream register bank.
REQ-004 SHALL have the port controller_clock, input, 1: single clock; all state changes occur on its rising edge.
REQ-005 SHALL have the port controller_reset, input, 1: reset that is asynchronous and active-low.
REQ-006 SHALL have the port req_valid, input, 1: a transfer request is present.
REQ-007 SHALL have the port req_ready, output, 1: the controller can accept a request.
REQ-008 SHALL have the port req_op, input, 2: operation code; 00 = MOVE (src to dst), 01 = LOAD (immediate to dst), 10 = READ (src to the response), 11 = reserved.
REQ-009 SHALL have the ports req_src and req_dst, input, ADDR_W each: source and destination register addresses.
REQ-010 SHALL have the port req_imm, input, DATA_W: immediate value for LOAD.
REQ-011 SHALL have the port register_addr, output, ADDR_W: address presented to the register bank.
REQ-012 SHALL have the port bus_register_input_en, output, 1: write strobe to the register bank.
REQ-013 SHALL have the port bus_register_out_en, output, 1: read-drive enable to the register bank.
REQ-014 SHALL have the port bus_data_in, input, DATA_W: sampled shared bus.
REQ-015 SHALL have the ports bus_data_out (output, DATA_W) and bus_data_out_en (output, 1): controller-side bus drive, connected through a tri-state buffer.
REQ-016 SHALL have the ports done (output, 1), resp_data (output, DATA_W) and resp_err (output, 1): completion pulse, result and error flag.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE and DONE.
REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, and req_op, req_src, req_dst and req_imm are latched at that edge.
REQ-019 SHALL, on acceptance, move MOVE and READ to the READ state and LOAD to the WRITE state; a reserved op SHALL go to DONE with resp_err=1 and no bus activity.
REQ-020 SHALL, in READ, drive register_addr=src and bus_register_out_en=1 with bus_data_out_en=0, and capture bus_data_in into the hold register at the end of the cycle.
REQ-021 SHALL, in WRITE, drive register_addr=dst, bus_data_out_en=1, bus_data_out=hold (MOVE) or imm (LOAD) and bus_register_input_en=1, with bus_register_out_en=0.
REQ-022 SHALL transition READ -> WRITE for MOVE and READ -> DONE for READ; WRITE SHALL go to DONE.
REQ-023 SHALL, in DONE, pulse done=1 for exactly one cycle, set resp_data=hold (MOVE, READ) or imm (LOAD), and return to IDLE.
REQ-024 SHALL give done latency from the accepting edge of 3 cycles for MOVE, 2 for LOAD, 2 for READ and 1 for a reserved op.
REQ-025 SHALL never assert bus_register_out_en and bus_data_out_en in the same cycle.
REQ-026 SHALL hold resp_data and resp_err stable until the next DONE.
REQ-027 SHALL drive register_addr=0 and all enables to 0 in IDLE.
REQ-028 SHALL let a MOVE with src==dst run the full READ/WRITE sequence.
REQ-029 SHALL accept a new request on the edge leaving DONE only if req_valid is high in IDLE; there is no back-to-back accept during DONE.

Reset
REQ-030 SHALL, on controller_reset low, immediately enter IDLE and set to 0: all enables, register_addr, bus_data_out, done, resp_data, resp_err and hold.
REQ-031 SHALL abort any in-flight transfer on reset, with no done pulse.

Configuration
REQ-032 SHALL support the macro XFER_ADDR_CHECK_EN.
- Defined: any used address >= NUM_REGS sends the request directly to DONE with resp_err=1 and no register strobes.
- Undefined: addresses are passed through unchecked, and resp_err is set only for the reserved op.

Structure
REQ-033 SHALL place the opcode and state enumerations plus the DATA_W and ADDR_W defaults in a shared package, bus_xfer_pkg.
REQ-034 SHALL use one sub-module, tri_state_buffer, instantiated on bus_data_out.

Verification
REQ-035 SHALL cover: reset, then MOVE src=1 dst=3 with bank reg1=0x00AB -> out_en cycle 1 with addr=1, in_en cycle 2 with addr=3 and bus_data_out=0x00AB, done at cycle 3 with resp_data=0x00AB.
REQ-036 SHALL cover: LOAD dst=2 imm=0xBEEF -> in_en with addr=2 at cycle 1, done at cycle 2 with resp_data=0xBEEF.
REQ-037 SHALL cover: READ src=0 with bus=0x1234 -> done at cycle 2 with resp_data=0x1234 and no in_en.
REQ-038 SHALL cover: req_valid held high across two requests -> the second is accepted only after done, with req_ready low throughout.
REQ-039 SHALL cover: with XFER_ADDR_CHECK_EN defined, MOVE dst=5 -> done at cycle 1 with resp_err=1 and no strobes.
REQ-040 SHALL cover: reset asserted during WRITE -> enables drop asynchronously, no done pulse, and IDLE with req_ready=1 after release.

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// Shared types and width defaults for the bus transfer controller.
// Contents: opcode and FSM state enumerations, and the default data,
// address and register-count sizes.
package bus_xfer_pkg;

  localparam int unsigned DATA_W_DEFAULT   = 16;
  localparam int unsigned ADDR_W_DEFAULT   = 6;
  localparam int unsigned NUM_REGS_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_MOVE = 2'b00,
    OP_LOAD = 2'b01,
    OP_READ = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/tri_state_buffer.sv
// Tri-state driver for the controller side of the shared bus.
// Ports:
//   data - value to drive
//   en   - drive enable
//   bus  - driven value when en=1, high impedance otherwise
module tri_state_buffer #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] data,
  input  logic         en,
  output logic [W-1:0] bus
);

  assign bus = en ? data : {W{1'bz}};

endmodule

// File: rtl/bus_transfer_controller.sv
// Register-bank transfer controller: MOVE (src->dst), LOAD (imm->dst) and
// READ (src->response) over a shared bus with separate read/write strobes.
// Optional build macro XFER_ADDR_CHECK_EN: reject any used register address
// >= NUM_REGS with resp_err=1 and no bus activity.
// Ports:
//   controller_clock / controller_reset - clock, async active-low reset
//   req_valid/req_ready, req_op/src/dst/imm - request handshake and payload
//   register_addr, bus_register_input_en, bus_register_out_en - bank control
//   bus_data_in, bus_data_out, bus_data_out_en - shared bus sample and drive
//   done, resp_data, resp_err - completion pulse and result
module bus_transfer_controller
  import bus_xfer_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic              controller_clock,
  input  logic              controller_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [DATA_W-1:0] req_imm,
  output logic [ADDR_W-1:0] register_addr,
  output logic              bus_register_input_en,
  output logic              bus_register_out_en,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_out_en,
  output logic              done,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

`ifdef XFER_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  state_e            state_q, state_d;
  op_e               op_q, op_d, req_op_c;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_en_d, rd_en_d, out_en_d, ready_d, done_d;
  logic [DATA_W-1:0] resp_data_d;
  logic              resp_err_d;
  logic              src_bad_c, dst_bad_c, addr_err_c;

  assign req_op_c  = op_e'(req_op);
  assign src_bad_c = 32'(req_src) >= NUM_REGS;
  assign dst_bad_c = 32'(req_dst) >= NUM_REGS;

  // Range violation for the addresses the requested op actually uses
  always_comb begin
    addr_err_c = 1'b0;
    unique case (req_op_c)
      OP_MOVE: addr_err_c = src_bad_c || dst_bad_c;
      OP_LOAD: addr_err_c = dst_bad_c;
      OP_READ: addr_err_c = src_bad_c;
      default: addr_err_c = 1'b0;
    endcase
    addr_err_c = ADDR_CHECK && addr_err_c;
  end

  // Next state and next registered outputs; outputs track the state entered
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    imm_d       = imm_q;
    hold_d      = hold_q;
    data_out_d  = '0;
    addr_d      = '0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    out_en_d    = 1'b0;
    done_d      = 1'b0;
    resp_data_d = resp_data;
    resp_err_d  = resp_err;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op_d  = req_op_c;
          dst_d = req_dst;
          imm_d = req_imm;
          if (req_op_c == OP_RSVD || addr_err_c) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else if (req_op_c == OP_LOAD) begin
            state_d    = ST_WRITE;
            addr_d     = req_dst;
            wr_en_d    = 1'b1;
            out_en_d   = 1'b1;
            data_out_d = req_imm;
          end else begin
            state_d = ST_READ;
            addr_d  = req_src;
            rd_en_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        // Bus value is captured here; MOVE forwards it straight to the drive
        hold_d = bus_data_in;
        if (op_q == OP_MOVE) begin
          state_d    = ST_WRITE;
          addr_d     = dst_q;
          wr_en_d    = 1'b1;
          out_en_d   = 1'b1;
          data_out_d = bus_data_in;
        end else begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          resp_data_d = bus_data_in;
          resp_err_d  = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d     = ST_DONE;
        done_d      = 1'b1;
        resp_data_d = (op_q == OP_LOAD) ? imm_q : hold_q;
        resp_err_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge controller_clock or negedge controller_reset) begin
    if (!controller_reset) begin
      state_q               <= ST_IDLE;
      op_q                  <= OP_MOVE;
      dst_q                 <= '0;
      imm_q                 <= '0;
      hold_q                <= '0;
      data_out_q            <= '0;
      register_addr         <= '0;
      bus_register_input_en <= 1'b0;
      bus_register_out_en   <= 1'b0;
      bus_data_out_en       <= 1'b0;
      req_ready             <= 1'b1;
      done                  <= 1'b0;
      resp_data             <= '0;
      resp_err              <= 1'b0;
    end else begin
      state_q               <= state_d;
      op_q                  <= op_d;
      dst_q                 <= dst_d;
      imm_q                 <= imm_d;
      hold_q                <= hold_d;
      data_out_q            <= data_out_d;
      register_addr         <= addr_d;
      bus_register_input_en <= wr_en_d;
      bus_register_out_en   <= rd_en_d;
      bus_data_out_en       <= out_en_d;
      req_ready             <= ready_d;
      done                  <= done_d;
      resp_data             <= resp_data_d;
      resp_err              <= resp_err_d;
    end
  end

  tri_state_buffer #(.W(DATA_W)) u_bus_drv (
    .data (data_out_q),
    .en   (bus_data_out_en),
    .bus  (bus_data_out)
  );

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed self-checking bench for bus_transfer_controller with a small
// register-bank model on the bus. Honours XFER_ADDR_CHECK_EN when defined.
module tb_bus_transfer_controller;
  import bus_xfer_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;

  logic              controller_clock = 1'b0;
  logic              controller_reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_src, req_dst;
  logic [DATA_W-1:0] req_imm;
  logic [ADDR_W-1:0] register_addr;
  logic              bus_register_input_en, bus_register_out_en;
  logic [DATA_W-1:0] bus_data_in, bus_data_out;
  logic              bus_data_out_en, done, resp_err;
  logic [DATA_W-1:0] resp_data;

  logic [DATA_W-1:0] bank [0:(1<<ADDR_W)-1];
  int checks = 0;
  int failures = 0;

  bus_transfer_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(4)) dut (
    .controller_clock      (controller_clock),
    .controller_reset      (controller_reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_op                (req_op),
    .req_src               (req_src),
    .req_dst               (req_dst),
    .req_imm               (req_imm),
    .register_addr         (register_addr),
    .bus_register_input_en (bus_register_input_en),
    .bus_register_out_en   (bus_register_out_en),
    .bus_data_in           (bus_data_in),
    .bus_data_out          (bus_data_out),
    .bus_data_out_en       (bus_data_out_en),
    .done                  (done),
    .resp_data             (resp_data),
    .resp_err              (resp_err)
  );

  always #5 controller_clock = ~controller_clock;

  // Register bank model: drives the bus on read enable, stores on write strobe
  assign bus_data_in = bus_register_out_en ? bank[register_addr] : '0;
  always @(posedge controller_clock)
    if (bus_register_input_en) bank[register_addr] <= bus_data_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] src, input logic [5:0] dst,
                       input logic [15:0] imm);
    @(negedge controller_clock);
    req_valid = 1'b1;
    req_op    = op;
    req_src   = src;
    req_dst   = dst;
    req_imm   = imm;
  endtask

  task automatic step();
    @(posedge controller_clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) bank[i] = '0;
    bank[1] = 16'h00AB;
    bank[0] = 16'h1234;
    controller_reset = 1'b0;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_src = '0;
    req_dst = '0;
    req_imm = '0;

    // Reset state
    repeat (2) step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rd_en", 32'(bus_register_out_en), 32'd0);
    chk("rst_wr_en", 32'(bus_register_input_en), 32'd0);
    chk("rst_out_en", 32'(bus_data_out_en), 32'd0);
    chk("rst_addr", 32'(register_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(resp_data), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    @(negedge controller_clock);
    controller_reset = 1'b1;

    // MOVE src=1 dst=3
    issue(2'b00, 6'd1, 6'd3, 16'h0);
    step(); req_valid = 1'b0;
    chk("mv_c1_rd_en", 32'(bus_register_out_en), 32'd1);
    chk("mv_c1_addr", 32'(register_addr), 32'd1);
    chk("mv_c1_out_en", 32'(bus_data_out_en), 32'd0);
    chk("mv_c1_wr_en", 32'(bus_register_input_en), 32'd0);
    chk("mv_c1_ready", 32'(req_ready), 32'd0);
    step();
    chk("mv_c2_wr_en", 32'(bus_register_input_en), 32'd1);
    chk("mv_c2_addr", 32'(register_addr), 32'd3);
    chk("mv_c2_out_en", 32'(bus_data_out_en), 32'd1);
    chk("mv_c2_rd_en", 32'(bus_register_out_en), 32'd0);
    chk("mv_c2_data", 32'(bus_data_out), 32'h00AB);
    chk("mv_c2_done", 32'(done), 32'd0);
    step();
    chk("mv_c3_done", 32'(done), 32'd1);
    chk("mv_c3_resp", 32'(resp_data), 32'h00AB);
    chk("mv_c3_err", 32'(resp_err), 32'd0);
    chk("mv_bank3", 32'(bank[3]), 32'h00AB);
    step();
    chk("mv_c4_done", 32'(done), 32'd0);
    chk("mv_c4_ready", 32'(req_ready), 32'd1);
    chk("mv_c4_resp_hold", 32'(resp_data), 32'h00AB);

    // LOAD dst=2 imm=0xBEEF
    issue(2'b01, 6'd0, 6'd2, 16'hBEEF);
    step(); req_valid = 1'b0;
    chk("ld_c1_wr_en", 32'(bus_register_input_en), 32'd1);
    chk("ld_c1_addr", 32'(register_addr), 32'd2);
    chk("ld_c1_data", 32'(bus_data_out), 32'hBEEF);
    chk("ld_c1_rd_en", 32'(bus_register_out_en), 32'd0);
    step();
    chk("ld_c2_done", 32'(done), 32'd1);
    chk("ld_c2_resp", 32'(resp_data), 32'hBEEF);
    chk("ld_bank2", 32'(bank[2]), 32'hBEEF);
    step();

    // READ src=0, bank drives 0x1234
    issue(2'b10, 6'd0, 6'd0, 16'h0);
    step(); req_valid = 1'b0;
    chk("rd_c1_rd_en", 32'(bus_register_out_en), 32'd1);
    chk("rd_c1_addr", 32'(register_addr), 32'd0);
    chk("rd_c1_wr_en", 32'(bus_register_input_en), 32'd0);
    step();
    chk("rd_c2_done", 32'(done), 32'd1);
    chk("rd_c2_resp", 32'(resp_data), 32'h1234);
    chk("rd_c2_wr_en", 32'(bus_register_input_en), 32'd0);
    step();

    // Reserved op
    issue(2'b11, 6'd1, 6'd2, 16'h0);
    step(); req_valid = 1'b0;
    chk("rsv_c1_done", 32'(done), 32'd1);
    chk("rsv_c1_err", 32'(resp_err), 32'd1);
    chk("rsv_c1_rd_en", 32'(bus_register_out_en), 32'd0);
    chk("rsv_c1_wr_en", 32'(bus_register_input_en), 32'd0);
    step();
    chk("rsv_c2_done", 32'(done), 32'd0);
    chk("rsv_c2_err_hold", 32'(resp_err), 32'd1);

    // req_valid held across two LOADs
    issue(2'b01, 6'd0, 6'd1, 16'h1111);
    step();
    req_dst = 6'd0;
    req_imm = 16'h2222;
    chk("b2b_c1_ready", 32'(req_ready), 32'd0);
    chk("b2b_c1_data", 32'(bus_data_out), 32'h1111);
    step();
    chk("b2b_c2_done", 32'(done), 32'd1);
    chk("b2b_c2_ready", 32'(req_ready), 32'd0);
    chk("b2b_c2_err", 32'(resp_err), 32'd0);
    step();
    chk("b2b_c3_ready", 32'(req_ready), 32'd1);
    chk("b2b_c3_wr_en", 32'(bus_register_input_en), 32'd0);
    step(); req_valid = 1'b0;
    chk("b2b_c4_wr_en", 32'(bus_register_input_en), 32'd1);
    chk("b2b_c4_addr", 32'(register_addr), 32'd0);
    chk("b2b_c4_data", 32'(bus_data_out), 32'h2222);
    chk("b2b_c4_ready", 32'(req_ready), 32'd0);
    step();
    chk("b2b_c5_done", 32'(done), 32'd1);
    chk("b2b_c5_resp", 32'(resp_data), 32'h2222);
    step();

    // MOVE to out-of-range dst=5
    bank[1] = 16'h00AB;
    issue(2'b00, 6'd1, 6'd5, 16'h0);
    step(); req_valid = 1'b0;
`ifdef XFER_ADDR_CHECK_EN
    chk("oor_c1_done", 32'(done), 32'd1);
    chk("oor_c1_err", 32'(resp_err), 32'd1);
    chk("oor_c1_rd_en", 32'(bus_register_out_en), 32'd0);
    chk("oor_c1_wr_en", 32'(bus_register_input_en), 32'd0);
    step();
`else
    chk("oor_c1_rd_en", 32'(bus_register_out_en), 32'd1);
    step();
    chk("oor_c2_wr_en", 32'(bus_register_input_en), 32'd1);
    chk("oor_c2_addr", 32'(register_addr), 32'd5);
    step();
    chk("oor_c3_done", 32'(done), 32'd1);
    chk("oor_c3_err", 32'(resp_err), 32'd0);
    chk("oor_c3_resp", 32'(resp_data), 32'h00AB);
    step();
`endif

    // Reset during WRITE of a MOVE
    issue(2'b00, 6'd1, 6'd3, 16'h0);
    step(); req_valid = 1'b0;
    step();
    chk("ra_pre_wr_en", 32'(bus_register_input_en), 32'd1);
    #2 controller_reset = 1'b0;
    #1;
    chk("ra_async_wr_en", 32'(bus_register_input_en), 32'd0);
    chk("ra_async_out_en", 32'(bus_data_out_en), 32'd0);
    chk("ra_async_addr", 32'(register_addr), 32'd0);
    chk("ra_async_done", 32'(done), 32'd0);
    step();
    chk("ra_held_done", 32'(done), 32'd0);
    @(negedge controller_clock);
    controller_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ra_post_done", 32'(done), 32'd0);
      chk("ra_post_ready", 32'(req_ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
